// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder: times key presses into dots/dashes and emits a 6-bit
// letter code with a one-cycle strobe after an inter-letter gap.
module morse_symbol_decoder #(
  parameter int GLITCH_MIN = 50000,
  parameter int DASH_MIN   = 15000000,
  parameter int GAP_MIN    = 30000000,
  parameter int CNT_W      = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key,
  output logic [5:0] letter,
  output logic       newletter,
  output logic       overflow
);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_MIN);
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_MIN);
  localparam logic [5:0]       NULL_C   = 6'd39;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_e;
  state_e state_q, state_d;
  logic sync_q, key_s_q;
  logic [CNT_W-1:0] press_q, press_d, gap_q, gap_d;
  logic [4:0] pat_q, pat_d;
  logic [2:0] len_q, len_d;
  logic bad_q, bad_d;
  logic [5:0] letter_q, letter_d, code;
  logic rel, valid, dash, emit;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync_q  <= key;
      key_s_q <= sync_q;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    case (state_q)
      IDLE:    state_d = key_s_q ? PRESS : IDLE;
      PRESS:   state_d = key_s_q ? PRESS : (valid || len_q != 3'd0) ? GAP : IDLE;
      GAP:     state_d = emit ? IDLE : key_s_q ? PRESS : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rel   = state_q == PRESS && !key_s_q;
    valid = press_q >= GLITCH_C;
    dash  = press_q >= DASH_C;
    emit  = state_q == GAP && gap_q == GAP_C;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_q  <= '0;
      gap_q    <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      bad_q    <= 1'b0;
      letter_q <= NULL_C;
    end else begin
      press_q  <= press_d;
      gap_q    <= gap_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      bad_q    <= bad_d;
      letter_q <= letter_d;
    end
  end
  // emit wins over a simultaneous rising key, so that press restarts from IDLE
  always_comb begin
    press_d  = press_q;
    gap_d    = gap_q;
    pat_d    = pat_q;
    len_d    = len_q;
    bad_d    = bad_q;
    letter_d = letter_q;
    if (key_s_q && (state_q == IDLE || (state_q == GAP && !emit))) press_d = ONE;
    else if (state_q == PRESS && key_s_q && press_q != '1) press_d = press_q + ONE;
    if (rel && valid) gap_d = ONE;
    else if (state_q == GAP && !emit && !key_s_q) gap_d = gap_q + ONE;
    if (rel && valid && len_q == 3'd5) bad_d = 1'b1;
    else if (rel && valid) begin
      pat_d = {pat_q[3:0], dash};
      len_d = len_q + 3'd1;
    end
    if (emit) begin
      pat_d    = '0;
      len_d    = '0;
      bad_d    = 1'b0;
      letter_d = code;
    end
  end
  always_comb begin
    newletter = emit;
    overflow  = rel && valid && len_q == 3'd5;
    letter    = emit ? code : letter_q;
  end
  // pat holds only the low len bits; dash = 1, newest symbol in bit 0
  always_comb begin
    code = NULL_C;
    if (!bad_q)
      case ({len_q, pat_q})
        {3'd5, 5'b11111}: code = 6'd0;
        {3'd5, 5'b01111}: code = 6'd1;
        {3'd5, 5'b00111}: code = 6'd2;
        {3'd5, 5'b00011}: code = 6'd3;
        {3'd5, 5'b00001}: code = 6'd4;
        {3'd5, 5'b00000}: code = 6'd5;
        {3'd5, 5'b10000}: code = 6'd6;
        {3'd5, 5'b11000}: code = 6'd7;
        {3'd5, 5'b11100}: code = 6'd8;
        {3'd5, 5'b11110}: code = 6'd9;
        {3'd2, 5'b00001}: code = 6'd10;
        {3'd4, 5'b01000}: code = 6'd11;
        {3'd4, 5'b01010}: code = 6'd12;
        {3'd3, 5'b00100}: code = 6'd13;
        {3'd1, 5'b00000}: code = 6'd14;
        {3'd4, 5'b00010}: code = 6'd15;
        {3'd3, 5'b00110}: code = 6'd16;
        {3'd4, 5'b00000}: code = 6'd17;
        {3'd2, 5'b00000}: code = 6'd18;
        {3'd4, 5'b00111}: code = 6'd19;
        {3'd3, 5'b00101}: code = 6'd20;
        {3'd4, 5'b00100}: code = 6'd21;
        {3'd2, 5'b00011}: code = 6'd22;
        {3'd2, 5'b00010}: code = 6'd23;
        {3'd3, 5'b00111}: code = 6'd24;
        {3'd4, 5'b00110}: code = 6'd25;
        {3'd4, 5'b01101}: code = 6'd26;
        {3'd3, 5'b00010}: code = 6'd27;
        {3'd3, 5'b00000}: code = 6'd28;
        {3'd1, 5'b00001}: code = 6'd29;
        {3'd3, 5'b00001}: code = 6'd30;
        {3'd4, 5'b00001}: code = 6'd31;
        {3'd3, 5'b00011}: code = 6'd32;
        {3'd4, 5'b01001}: code = 6'd33;
        {3'd4, 5'b01011}: code = 6'd34;
        {3'd4, 5'b01100}: code = 6'd35;
        default:          code = NULL_C;
      endcase
  end
endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb_morse_symbol_decoder: drives key waveforms as level runs; a run-level model
// predicts strobes into a scoreboard that a negedge monitor drains.
module tb_morse_symbol_decoder;
  localparam int GLITCH_MIN = 2, DASH_MIN = 8, GAP_MIN = 12;
  logic clock = 1'b0, reset = 1'b1, key = 1'b0;
  logic [5:0] letter;
  logic newletter, overflow;
  int cyc = 0, n_cmp = 0, n_bad = 0, exp_letter = 39, g = 0;
  typedef struct {int at; int kind; int val;} ev_t;
  ev_t sb[$];
  string syms = "";
  bit bad_m = 1'b0, prio = 1'b0;
  string morse[36] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----.", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--",
    "-..-", "-.--", "--.."};

  morse_symbol_decoder #(.GLITCH_MIN(GLITCH_MIN), .DASH_MIN(DASH_MIN), .GAP_MIN(GAP_MIN), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .key(key), .letter(letter), .newletter(newletter), .overflow(overflow));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int lookup();
    if (bad_m) return 39;
    for (int i = 0; i < 36; i++) if (morse[i] == syms) return i;
    return 39;
  endfunction

  task automatic push(input int at, input int kind, input int val);
    ev_t e;
    e.at = at; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  // t = first synchronized cycle of this run; n = run length in cycles
  task automatic model(input bit lv, input int n, input int t);
    int eff, need;
    string c;
    if (lv) begin
      eff = prio ? n - 1 : n;
      prio = 1'b0;
      if (eff >= GLITCH_MIN) begin
        c = eff >= DASH_MIN ? "-" : ".";
        if (syms.len() == 5) begin
          bad_m = 1'b1;
          push(t + n, 1, 0);
        end else syms = {syms, c};
        g = 1;
      end
    end else begin
      prio = 1'b0;
      if (syms.len() > 0) begin
        need = GAP_MIN - g + 1;
        if (n >= need) begin
          push(t + need, 0, lookup());
          prio = n == need;
          syms = "";
          bad_m = 1'b0;
        end else g = g + n - 1;
      end
    end
  endtask

  task automatic seg(input bit lv, input int n);
    model(lv, n, cyc + 2);
    key = lv;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      seg(1'b1, s[i] == "-" ? 10 : s[i] == "g" ? 1 : 4);
      seg(1'b0, i == s.len() - 1 ? gap : 3);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    syms = ""; bad_m = 1'b0; prio = 1'b0; g = 0;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (reset) exp_letter = 39;
    else begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        chk("missing_strobe_cycle", -1, sb[0].at);
        void'(sb.pop_front());
      end
      if (newletter || overflow) begin
        chk("strobe_exclusive", int'(newletter && overflow), 0);
        if (sb.size() == 0) chk("unexpected_strobe_cycle", cyc, -1);
        else begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.at);
          chk("strobe_kind_overflow", int'(overflow), e.kind);
          if (e.kind == 0) begin
            chk("letter_code", int'(letter), e.val);
            exp_letter = e.val;
          end
        end
      end else chk("letter_hold", int'(letter), exp_letter);
    end
  end

  initial begin
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b0;
    chk("reset_letter", int'(letter), 39);
    chk("reset_newletter", int'(newletter), 0);
    chk("reset_overflow", int'(overflow), 0);
    seg(1'b0, 50);
    send(".-", 20);
    send(".", 20);
    send("-", 20);
    send("-----", 20);
    send(".....", 20);
    send(".----", 20);
    send("g", 20);
    send(".g", 20);
    send("......", 20);
    send("..--", 20);
    send("-.", 20);
    send(".-", 5);
    do_reset();
    chk("reset_mid_letter", int'(letter), 39);
    send("...", 20);
    seg(1'b1, 4);
    seg(1'b0, GAP_MIN);
    send("-", 20);
    for (int k = 0; k < 40; k++) begin
      int ns;
      ns = int'($urandom_range(1, 6));
      for (int j = 0; j < ns; j++) begin
        if ($urandom_range(0, 7) == 0) begin
          seg(1'b1, 1);
          seg(1'b0, int'($urandom_range(1, 4)));
        end
        seg(1'b1, $urandom_range(0, 1) == 1 ? int'($urandom_range(8, 14)) : int'($urandom_range(2, 7)));
        seg(1'b0, j == ns - 1 ? int'($urandom_range(10, 18)) : int'($urandom_range(1, 6)));
      end
    end
    seg(1'b1, 4);
    seg(1'b0, 40);
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
